// File: rtl/mult_div_unit.sv
// Multi-cycle signed 32-bit multiply/divide unit for the execute stage.
// Define MULTDIV_BOOTH_EN for radix-4 Booth multiply (16 iterations); default is radix-2 (32).
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    // state | meaning
    // IDLE  | waiting for a start pulse
    // MUL   | multiply iterations
    // DIV   | divide iterations, then one sign-fix cycle at count 32
    // DONE  | result valid, ready strobe high for one cycle
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

`ifdef MULTDIV_BOOTH_EN
    localparam logic [5:0] MUL_LAST = 6'd15;
`else
    localparam logic [5:0] MUL_LAST = 6'd31;
`endif
    localparam logic [5:0] DIV_FIX = 6'd32;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] opa_q, opa_d;
    logic        neg_q, neg_d;
    logic        div_zero_q, div_zero_d;
    logic        div_ovf_q, div_ovf_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
`ifdef MULTDIV_BOOTH_EN
    logic        qm1_q, qm1_d;
`endif

    logic        start;
    logic [31:0] abs_a, abs_b;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_trial;
    logic [31:0] quot_fixed;

    assign start = ctrl_MULT | ctrl_DIV;
    assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            prod_q     <= 64'd0;
            opa_q      <= 32'd0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            res_q      <= 32'd0;
            exc_q      <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
            qm1_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            opa_q      <= opa_d;
            neg_q      <= neg_d;
            div_zero_q <= div_zero_d;
            div_ovf_q  <= div_ovf_d;
            res_q      <= res_d;
            exc_q      <= exc_d;
`ifdef MULTDIV_BOOTH_EN
            qm1_q      <= qm1_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = ctrl_MULT ? MUL : DIV;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                MUL: begin
                    if (cnt_q == MUL_LAST) state_d = DONE;
                    else                   cnt_d   = cnt_q + 6'd1;
                end
                DIV: begin
                    if (cnt_q == DIV_FIX) state_d = DONE;
                    else                  cnt_d   = cnt_q + 6'd1;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef MULTDIV_BOOTH_EN
    logic [33:0] bo_hi, bo_pp, bo_sum;
    always_comb begin
        bo_hi = {{2{prod_q[63]}}, prod_q[63:32]};
        case ({prod_q[1:0], qm1_q})
            3'b001, 3'b010: bo_pp = {{2{opa_q[31]}}, opa_q};
            3'b011:         bo_pp = {opa_q[31], opa_q, 1'b0};
            3'b100:         bo_pp = -{opa_q[31], opa_q, 1'b0};
            3'b101, 3'b110: bo_pp = -{{2{opa_q[31]}}, opa_q};
            default:        bo_pp = 34'd0;
        endcase
        bo_sum   = bo_hi + bo_pp;
        mul_next = {bo_sum, prod_q[31:2]};
    end
`else
    logic [32:0] mul_addend, mul_sum;
    always_comb begin
        mul_addend = prod_q[0] ? {opa_q[31], opa_q} : 33'd0;
        // Last multiplier bit carries negative weight, so it subtracts.
        if (cnt_q == MUL_LAST) mul_sum = {prod_q[63], prod_q[63:32]} - mul_addend;
        else                   mul_sum = {prod_q[63], prod_q[63:32]} + mul_addend;
        mul_next = {mul_sum, prod_q[31:1]};
    end
`endif

    always_comb begin
        div_shift  = {prod_q[63:32], prod_q[31]};
        div_trial  = div_shift - {1'b0, opa_q};
        quot_fixed = neg_q ? -prod_q[31:0] : prod_q[31:0];
    end

    always_comb begin
        prod_d     = prod_q;
        opa_d      = opa_q;
        neg_d      = neg_q;
        div_zero_d = div_zero_q;
        div_ovf_d  = div_ovf_q;
        res_d      = res_q;
        exc_d      = exc_q;
`ifdef MULTDIV_BOOTH_EN
        qm1_d      = qm1_q;
`endif
        if (start) begin
            if (ctrl_MULT) begin
                opa_d  = data_operandA;
                prod_d = {32'd0, data_operandB};
`ifdef MULTDIV_BOOTH_EN
                qm1_d  = 1'b0;
`endif
            end else begin
                opa_d      = abs_b;
                prod_d     = {32'd0, abs_a};
                neg_d      = data_operandA[31] ^ data_operandB[31];
                div_zero_d = (data_operandB == 32'd0);
                div_ovf_d  = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            end
        end else if (state_q == MUL) begin
            prod_d = mul_next;
`ifdef MULTDIV_BOOTH_EN
            qm1_d  = prod_q[1];
`endif
            if (cnt_q == MUL_LAST) begin
                res_d = mul_next[31:0];
                exc_d = (mul_next[63:32] != {32{mul_next[31]}});
            end
        end else if (state_q == DIV) begin
            if (cnt_q != DIV_FIX) begin
                prod_d[63:32] = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
                prod_d[31:0]  = {prod_q[30:0], ~div_trial[32]};
            end else if (div_zero_q) begin
                res_d = 32'd0;
                exc_d = 1'b1;
            end else if (div_ovf_q) begin
                res_d = 32'h8000_0000;
                exc_d = 1'b1;
            end else begin
                res_d = quot_fixed;
                exc_d = 1'b0;
            end
        end
    end

    always_comb begin
        data_resultRDY = (state_q == DONE);
        data_result    = res_q;
        data_exception = exc_q;
    end

endmodule
